// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: DEPTH-entry register bank behind a single-outstanding
// sel/wr/ready request port with byte strobes, configurable wait states,
// a one-cycle response strobe and out-of-range error reporting.
// Optional parity protection is compiled in with REG_BANK_CTRL_PARITY_EN.
module reg_bank_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = DATA_WIDTH'(32'h1234_5678),
    parameter int WAIT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sel,
    input  logic                      wr,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      par_inject,
    output logic                      ready,
    output logic                      resp_valid,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      err,
    output logic                      par_err
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT_S, RESP} state_t;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [NB-1:0]         wstrb;
        logic                  inj;
    } req_t;

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt;
    req_t                   req_q, cur;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DATA_WIDTH-1:0]  rd_word, merged;
    logic [IDX_W-1:0]       idx;
    logic                   in_range, commit;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   err_q, par_q;

    // With zero wait states the commit happens on the accept edge itself,
    // so the live inputs stand in for the captured request while idle.
    assign cur      = (state == IDLE) ? req_t'{wr, addr, wdata, wstrb, par_inject} : req_q;
    assign in_range = ({1'b0, cur.addr} < (ADDR_WIDTH + 1)'(DEPTH));
    assign idx      = cur.addr[IDX_W-1:0];
    assign commit   = (state_nx == RESP);
    assign rd_word  = mem[idx];

    // Byte-merge of write data over the current entry contents
    always_comb begin
        merged = rd_word;
        for (int b = 0; b < NB; b++)
            if (cur.wstrb[b]) merged[8*b +: 8] = cur.wdata[8*b +: 8];
    end

    // State register, wait counter and request capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && sel) begin
                cnt   <= CNT_LOAD;
                req_q <= cur;
            end else if (state == WAIT_S && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx   = state;
        ready      = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (sel) state_nx = (WAIT_CYCLES > 0) ? WAIT_S : RESP;
            end
            WAIT_S: if (cnt == '0) state_nx = RESP;
            RESP: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Register bank: writes land only on the edge entering RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
        end else if (commit && cur.wr && in_range) begin
            mem[idx] <= merged;
        end
    end

`ifdef REG_BANK_CTRL_PARITY_EN
    logic par_mem [DEPTH];

    // Stored even parity per entry; par_inject corrupts it for test
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) par_mem[i] <= ^RESET_VAL;
        end else if (commit && cur.wr && in_range) begin
            par_mem[idx] <= (^merged) ^ cur.inj;
        end
    end

    // Response capture, sampled from the pre-commit bank contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            par_q   <= 1'b0;
        end else if (commit) begin
            err_q   <= ~in_range;
            rdata_q <= (!cur.wr && in_range) ? rd_word : '0;
            par_q   <= !cur.wr && in_range && (par_mem[idx] != ^rd_word);
        end
    end
`else
    logic unused_inj;
    assign unused_inj = cur.inj;

    // Response capture, sampled from the pre-commit bank contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (commit) begin
            err_q   <= ~in_range;
            rdata_q <= (!cur.wr && in_range) ? rd_word : '0;
        end
    end

    assign par_q = 1'b0;
`endif

    assign rdata   = resp_valid ? rdata_q : '0;
    assign err     = resp_valid & err_q;
    assign par_err = resp_valid & par_q;

endmodule

// File: doc/reg_bank_ctrl.md
Name: reg_bank_ctrl

Overview:
Parametrised successor of the team's register control block. It holds a DEPTH-entry register bank behind a single-outstanding sel/wr/ready request interface. Over the previous generation it adds:
- byte-strobe writes
- a configurable wait-state count
- an explicit one-cycle response strobe
- out-of-range address error reporting

It sits between the bus-side decoder and configuration consumers.

Parameters:
- ADDR_WIDTH, 8, address width.
- DATA_WIDTH, 32, data width. Must be a multiple of 8.
- DEPTH, 256, number of entries. Must be ≤ 2**ADDR_WIDTH.
- RESET_VAL, 32'h1234_5678, reset value of every entry. Truncated to DATA_WIDTH.
- WAIT_CYCLES, 0, extra wait states inserted between accept and response (0..15).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sel  in  1  request valid.
- wr  in  1  1 = write, 0 = read. Sampled at accept.
- addr  in  ADDR_WIDTH  entry index. Sampled at accept.
- wdata  in  DATA_WIDTH  write data. Sampled at accept.
- wstrb  in  DATA_WIDTH/8  byte enables. Bit i covers wdata[8i+7:8i].
- par_inject  in  1  test hook (see Optional Feature).
- ready  out  1  block idle; a request can be accepted.
- resp_valid  out  1  one-cycle response strobe.
- rdata  out  DATA_WIDTH  read data. Valid only while resp_valid=1, otherwise 0.
- err  out  1  out-of-range address. Valid only while resp_valid=1, otherwise 0.
- par_err  out  1  parity error on read. Valid only while resp_valid=1, otherwise 0.

Behaviour:
- Reset (asynchronous, any time):
  - all entries = RESET_VAL; state = IDLE.
  - ready=1; resp_valid=0, rdata=0, err=0, par_err=0.
  - An in-flight request is dropped; its write is not committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE: ready=1.
  - Accept when sel=1 on a rising edge; capture wr/addr/wdata/wstrb.
  - Next state is WAIT (counter loaded with WAIT_CYCLES-1) if WAIT_CYCLES>0, else RESP.
  - sel=0: stay in IDLE.
- WAIT: ready=0. Counter decrements each cycle; at 0 go to RESP.
- RESP: ready=0, resp_valid=1 for exactly one cycle, then IDLE. ready=1 again on the following cycle.
- Latency: accept at edge T → resp_valid high in cycle T+WAIT_CYCLES+1 → ready high at T+WAIT_CYCLES+2. Minimum 2 cycles per access.
- sel while ready=0 is ignored; no queuing.
- Write commit:
  - On the edge entering RESP: entry[addr] byte i ← wdata byte i where wstrb[i]=1, else unchanged.
  - wstrb=0 is a legal no-op write; err=0 unless addr is out of range.
- Read: rdata in RESP = entry[addr] as committed before this access.
- Out of range (addr ≥ DEPTH):
  - write: no entry modified.
  - read: rdata=0.
  - both: err=1 in RESP.
- Back-to-back: a read accepted right after a write to the same address returns the new data.
- Wait counter width: $clog2(WAIT_CYCLES+1), minimum 1.

Optional Feature:
- Macro REG_BANK_CTRL_PARITY_EN.
- Defined:
  - Each entry stores one extra even-parity bit (XOR of all data bits). It is recomputed on every committed write over the merged word; on reset it holds the parity of RESET_VAL.
  - If par_inject=1 at accept of an in-range write, the stored parity bit is inverted.
  - On an in-range read, par_err=1 in RESP if the stored parity does not match the recomputed parity. rdata is still returned.
- Not defined: no parity storage; par_inject is ignored; par_err is tied to 0.

Test Plan (DEPTH=16, DATA_WIDTH=32, RESET_VAL=32'h1234_5678, WAIT_CYCLES=2 unless noted):
1. Release rst, read addr 5 → resp_valid in cycle T+3 with rdata=32'h1234_5678, err=0. ready low for 3 cycles, high at T+4.
2. Write addr 3, wdata=32'hAABB_CCDD, wstrb=4'b0101, then read addr 3 → rdata=32'h12BB_56DD.
3. Read addr 20 → err=1, rdata=0. Write addr 20 with 32'hFFFF_FFFF, then read addr 4 → 32'h1234_5678 (no aliasing).
4. Hold sel=1 continuously with alternating write/read to addr 7 → exactly one accept per 4 cycles; each read returns the preceding write's data.
5. Assert rst during WAIT of a write to addr 2 with 32'h0 → ready=1 immediately; subsequent read of addr 2 returns 32'h1234_5678.
6. With REG_BANK_CTRL_PARITY_EN and WAIT_CYCLES=0, write addr 1 with par_inject=1, then read addr 1 → par_err=1, rdata = written data, response 1 cycle after accept. Without the macro → par_err=0.
